// File: rtl/fast_ring_scheduler.sv
// fast_ring_scheduler: FAST corner test sequencer, one shared comparator over the 16-pixel ring, longest circular run scoring
module fast_ring_scheduler #(
  parameter int N_MIN = 9,
  parameter int TH_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   center,
  input  logic [127:0] ring,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_corner,
  output logic [4:0]   out_score
);
  typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;
  state_t state, state_n;
  logic [7:0] c_r;
  logic [127:0] ring_r;
  logic [3:0] idx;
  logic [4:0] run, max_run, lead, score;
  logic lead_open, diff;
  logic [8:0] band, lo, hi, pix;
  logic [5:0] wrap, best;
  assign band = {1'b0, c_r >> TH_SHIFT};
  assign lo = {1'b0, c_r} - band;
  assign hi = {1'b0, c_r} + band;
  assign pix = {1'b0, ring_r[{idx, 3'b000} +: 8]};
  assign diff = pix < lo || pix >= hi;
  // run holds the trailing run at EVAL, so run+lead joins the run that wraps past j=0
  assign wrap = {1'b0, run} + {1'b0, lead};
  assign best = {1'b0, max_run} > wrap ? {1'b0, max_run} : wrap;
  assign score = lead_open ? 5'd16 : best > 6'd16 ? 5'd16 : best[4:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? SCAN : IDLE) :
              state == SCAN ? (idx == 4'd15 ? EVAL : SCAN) :
              state == EVAL ? DONE : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      c_r <= '0;
      ring_r <= '0;
      idx <= '0;
      run <= '0;
      max_run <= '0;
      lead <= '0;
      lead_open <= 1'b0;
      out_corner <= 1'b0;
      out_score <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          c_r <= center;
          ring_r <= ring;
          idx <= '0;
          run <= '0;
          max_run <= '0;
          lead <= '0;
          lead_open <= 1'b1;
        end
        SCAN: begin
          idx <= idx + 4'd1;
          run <= diff ? run + 5'd1 : 5'd0;
          lead <= diff && lead_open ? lead + 5'd1 : lead;
          lead_open <= lead_open && diff;
          max_run <= diff && run + 5'd1 > max_run ? run + 5'd1 : max_run;
        end
        EVAL: begin
          out_score <= score;
          out_corner <= score >= 5'(N_MIN);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fast_ring_scheduler.sv
// tb_fast_ring_scheduler: directed and randomized jobs checked against a brute-force circular-run model
module tb_fast_ring_scheduler;
  localparam int N_MIN = 9;
  localparam int TH = 2;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, out_corner;
  logic [7:0] center = 0;
  logic [127:0] ring = 0;
  logic [4:0] out_score;
  int tests = 0, fails = 0;

  fast_ring_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .center(center), .ring(ring), .out_valid(out_valid), .out_ready(out_ready),
    .out_corner(out_corner), .out_score(out_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ref_score(input logic [7:0] c, input logic [127:0] r);
    int i, lo, hi, p, best, len;
    bit d[16];
    i = int'(c) >> TH;
    lo = int'(c) - i;
    hi = int'(c) + i;
    for (int j = 0; j < 16; j++) begin
      p = int'(r[8*j +: 8]);
      d[j] = (p < lo) || (p >= hi);
    end
    best = 0;
    for (int s = 0; s < 16; s++) begin
      len = 0;
      while (len < 16 && d[(s + len) % 16]) len++;
      if (len > best) best = len;
    end
    return best;
  endfunction

  function automatic logic [127:0] mk(input logic [15:0] mask, input logic [7:0] a, input logic [7:0] b);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = mask[j] ? a : b;
    return r;
  endfunction

  function automatic logic [7:0] rpix(input logic [7:0] c);
    int i, lo, hi, v;
    i = int'(c) >> TH;
    lo = int'(c) - i;
    hi = int'(c) + i;
    case ($urandom_range(4))
      0: v = int'($urandom_range(255));
      1: v = lo;
      2: v = lo > 0 ? lo - 1 : 0;
      3: v = hi > 255 ? 255 : hi;
      default: v = hi > 0 ? hi - 1 : 0;
    endcase
    return 8'(v);
  endfunction

  task automatic job(input logic [7:0] c, input logic [127:0] r, input int hold, input bit early, input string tag);
    int n, es;
    es = ref_score(c, r);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    center = c;
    ring = r;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    n = 1;
    if (early) out_ready = 1;
    chk({tag, "_in_ready_scan"}, in_ready, 0);
    while (out_valid !== 1'b1 && n < 40) begin
      in_valid = n < 15 ? 1'($urandom_range(1)) : 1'b0;
      center = 8'($urandom);
      ring = {4{$urandom}};
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    chk({tag, "_latency"}, n, 18);
    chk({tag, "_score"}, out_score, es);
    chk({tag, "_corner"}, out_corner, es >= N_MIN);
    if (early) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, out_valid, 0);
      out_ready = 0;
    end else begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'($urandom_range(1));
        center = 8'($urandom);
        ring = {4{$urandom}};
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_score"}, out_score, es);
        chk({tag, "_hold_corner"}, out_corner, es >= N_MIN);
        chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({tag, "_valid_cleared"}, out_valid, 0);
    end
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_score_retained"}, out_score, es);
  endtask

  initial begin
    logic [7:0] c;
    logic [127:0] r;
    int bad;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_corner", out_corner, 0);

    job(8'd100, mk(16'h0000, 8'd100, 8'd100), 0, 0, "flat");
    job(8'd100, mk(16'h01FF, 8'd200, 8'd100), 2, 0, "run9");
    job(8'd100, mk(16'h00FF, 8'd200, 8'd100), 0, 0, "run8");
    job(8'd100, mk(16'hF01F, 8'd20, 8'd100), 1, 0, "wrap9");
    job(8'd100, mk(16'h0000, 8'd0, 8'd125), 0, 0, "eq_hi");
    job(8'd100, mk(16'h0000, 8'd0, 8'd75), 0, 0, "eq_lo");
    job(8'd100, mk(16'h0000, 8'd0, 8'd74), 0, 0, "below_lo");
    job(8'd0, {4{$urandom}}, 0, 0, "center0");
    job(8'd100, mk(16'h01FF, 8'd200, 8'd100), 10, 0, "hold10");
    job(8'd100, mk(16'hF01F, 8'd20, 8'd100), 0, 1, "early_ready");

    center = 8'd100;
    ring = mk(16'h00FF, 8'd200, 8'd100);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (8) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("midrst_no_output", bad, 0);
    job(8'd100, mk(16'h01FF, 8'd200, 8'd100), 0, 0, "post_rst");

    for (int t = 0; t < 30; t++) begin
      c = 8'($urandom);
      if (t % 2 == 0) begin
        for (int j = 0; j < 16; j++) r[8*j +: 8] = rpix(c);
      end else begin
        r = mk(16'($urandom), c > 8'd127 ? 8'd0 : 8'd255, c);
      end
      job(c, r, int'($urandom_range(3)), bit'($urandom_range(1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
